// File: rtl/mul_32_seq.sv
// mul_32_seq: sequential 32x32 shift-add multiplier, 64-bit product.
// One add/shift iteration per clock through IDLE -> CALC (32 cycles) -> FIX -> DONE.
// From the start edge to the done cycle takes 34 cycles. One operation completes
// every 35 cycles.
//
// Build option: define MUL_SIGNED_EN for two's-complement signed operands.
// When it is undefined, A and B are treated as unsigned.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request; sampled only while busy=0
//   A, B   32-bit multiplicand / multiplier; latched with start
//   P      64-bit product; holds until the next completed operation
//   busy   high in CALC, FIX and DONE
//   done   one-cycle pulse; P is valid from the done cycle onward
module mul_32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] P,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  mcand, mcand_nxt;
    logic          c, c_nxt;
    logic [W-1:0]  hi, hi_nxt;
    logic [W-1:0]  lo, lo_nxt;
    logic [PW-1:0] p_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic [W:0]    sum;

`ifdef MUL_SIGNED_EN
    logic          s, s_nxt;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;

    // The negation wraps 0x80000000 onto itself, which read as unsigned is 2^31.
    assign a_mag = A[W-1] ? W'(-A) : A;
    assign b_mag = B[W-1] ? W'(-B) : B;
`endif

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    // The 33-bit sum keeps the carry.
    assign sum = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {c, hi};

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mcand_nxt = mcand;
        c_nxt     = c;
        hi_nxt    = hi;
        lo_nxt    = lo;
        p_nxt     = P;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
`ifdef MUL_SIGNED_EN
        s_nxt     = s;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MUL_SIGNED_EN
                    mcand_nxt = a_mag;
                    lo_nxt    = b_mag;
                    s_nxt     = A[W-1] ^ B[W-1];
`else
                    mcand_nxt = A;
                    lo_nxt    = B;
`endif
                    c_nxt     = 1'b0;
                    hi_nxt    = '0;
                    cnt_nxt   = CW'(W);
                    busy_nxt  = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                // Shift {c,hi,lo} right by one. This drops the consumed multiplier bit.
                c_nxt   = 1'b0;
                hi_nxt  = sum[W:1];
                lo_nxt  = {sum[0], lo[W-1:1]};
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
`ifdef MUL_SIGNED_EN
                p_nxt = s ? PW'(-{hi, lo}) : {hi, lo};
`else
                p_nxt = {hi, lo};
`endif
                done_nxt  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            mcand <= '0;
            c     <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MUL_SIGNED_EN
            s     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mcand <= mcand_nxt;
            c     <= c_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            P     <= p_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
`ifdef MUL_SIGNED_EN
            s     <= s_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mul_32_seq.sv
// Testbench for mul_32_seq.
// A cycle-level reference model is checked against busy/done/P on every cycle.
// Hand-computed product literals pin the model itself.
module tb_mul_32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [63:0] P;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    mul_32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference product computed with plain wide arithmetic
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
        return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    // Timeline model: accept at edge N, result and done at N+33, idle after N+34
    logic        m_busy, m_done;
    logic [63:0] m_p, m_pend;
    int          m_k;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_p    <= '0;
            m_pend <= '0;
            m_k    <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_pend <= ref_mul(A, B);
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k == 32) begin
                m_p    <= m_pend;
                m_done <= 1'b1;
            end else if (m_k == 33) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and compare all outputs against the model
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_P", P, m_p);
        end
    endtask

    // Issue one operation from an IDLE negedge and wait for done.
    // The wait is bounded.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p_out, output int st_cyc);
        int n;
        A = a;
        B = b;
        start = 1'b1;
        st_cyc = cyc;
        tick();
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'd34);
        p_out = P;
        tick();
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    logic [63:0] p;
    logic [31:0] ra, rb;
    int st, prev_st, ndone;

    initial begin
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_P", P, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        do_op(32'd7, 32'd6, p, st);
        check("p_7x6", p, 64'h0000_0000_0000_002A);

`ifdef MUL_SIGNED_EN
        do_op(32'hFFFF_FFFD, 32'd5, p, st);
        check("p_m3x5", p, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(32'h8000_0000, 32'h8000_0000, p, st);
        check("p_min_sq", p, 64'h4000_0000_0000_0000);
        do_op(32'hFFFF_FFFB, 32'd0, p, st);
        check("p_neg_zero", p, 64'd0);
`else
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, st);
        check("p_max_sq", p, 64'hFFFF_FFFE_0000_0001);
`endif

        // A start issued while busy is dropped, not queued
        A = 32'd3; B = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        A = 32'd9; B = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                p = P;
            end
        end
        check("reject_ndone", 64'(ndone), 64'd1);
        check("reject_P", p, 64'h0C);

        // A reset mid-calculation aborts the operation without a done
        A = 32'd100; B = 32'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        check("abort_P", P, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_op(32'd2, 32'd3, p, st);
        check("p_2x3", p, 64'd6);

        // Back-to-back operations, each starting on the first IDLE cycle
        prev_st = 0;
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(ra, rb, p, st);
            check("b2b_P", p, ref_mul(ra, rb));
            if (i > 0) check("b2b_spacing", 64'(st - prev_st), 64'd35);
            prev_st = st;
        end

        // Further random operands, including sign/magnitude corners
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'hFFFF_FFFF;
            do_op(ra, rb, p, st);
            check("rand_P", p, ref_mul(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
